// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path.
//
// Segment encodings are active-low for a common-anode display, bit order
// seg[0]=a .. seg[6]=g. Slot indices name which counter digit occupies each
// scan slot (and therefore which anode bit drives it).
package seg7_pkg;

  // All cathodes released: nothing lit.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // Scan slot order, rightmost digit first.
  localparam logic [1:0] SLOT_SEC_ONE = 2'd0;
  localparam logic [1:0] SLOT_SEC_TEN = 2'd1;
  localparam logic [1:0] SLOT_MIN_ONE = 2'd2;
  localparam logic [1:0] SLOT_MIN_TEN = 2'd3;

  // All anodes off (active-low).
  localparam logic [3:0] AN_OFF = 4'hF;

  // Phase within one digit slot.
  typedef enum logic {
    PhBlank,
    PhDrive
  } slot_phase_e;

  // Active-low one-hot anode pattern selecting slot idx.
  function automatic logic [3:0] anode_for_slot(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
//
// Ports:
//   bcd  in  4  digit value
//   seg  out 7  active-low cathodes, seg[0]=a .. seg[6]=g
//
// Non-decimal codes (10..15) show nothing rather than hex glyphs, so a
// corrupted digit reads as a dark position instead of a misleading symbol.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment driver for the stopwatch display.
//
// Scans four BCD digits onto a common-anode, active-low display. Each digit
// owns a slot of SCAN_DIV cycles; the first GUARD cycles of every slot keep
// all anodes off so the previous digit's cathode pattern never ghosts onto
// the next anode. The digits are latched once per frame (at the start of
// slot 0) so a counter rollover mid-frame cannot show a torn time.
// Blink enables and decimal points are used live so UI changes appear on the
// next slot without waiting for a frame boundary.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   GUARD      blank cycles at the start of each slot (0 < GUARD < SCAN_DIV)
//   BLINK_DIV  clk cycles per blink half-period (>= 1)
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   sec_one      in   4  BCD seconds units  (slot 0, an[0])
//   sec_ten      in   4  BCD seconds tens   (slot 1, an[1])
//   min_one      in   4  BCD minutes units  (slot 2, an[2])
//   min_ten      in   4  BCD minutes tens   (slot 3, an[3])
//   blink_en     in   4  per-slot blink enable
//   dp_mask      in   4  per-slot decimal point enable
//   an           out  4  anode enables, active-low
//   seg          out  7  cathodes, active-low, seg[0]=a .. seg[6]=g
//   dp           out  1  decimal-point cathode, active-low
//   frame_start  out  1  one-cycle pulse the cycle after each digit snapshot
module seven_seg_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned GUARD     = 1000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_one,
  input  logic [3:0] sec_ten,
  input  logic [3:0] min_one,
  input  logic [3:0] min_ten,
  input  logic [3:0] blink_en,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  // A divider of 1 would give a zero-width counter; keep one bit that simply
  // stays at zero so the phase toggles every cycle.
  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [ScanW-1:0]  GuardEnd  = ScanW'(GUARD);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [3:0]        digit_q [4];

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       frame_start_q, frame_start_d;

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  logic scan_wrap;
  logic blink_wrap;
  logic snapshot;

  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanLast);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

    blink_wrap    = (blink_cnt_q == BlinkLast);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;

    // First cycle of slot 0 starts a new frame.
    snapshot = (idx_q == SLOT_SEC_ONE) && (scan_cnt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Slot sequencing and output decode
  // ---------------------------------------------------------------------------
  slot_phase_e phase;
  logic        dark;
  logic [3:0]  cur_digit;
  logic [6:0]  cur_seg;

  // The snapshot cycle always falls inside BLANK (GUARD > 0), so decoding the
  // previously latched value there is never visible.
  assign cur_digit = digit_q[idx_q];

  bcd_to_seg7 u_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    phase = (scan_cnt_q < GuardEnd) ? PhBlank : PhDrive;
    // A blinking digit in its off half-period looks exactly like the guard.
    dark  = (phase == PhBlank) || (blink_phase_q && blink_en[idx_q]);

    an_d          = AN_OFF;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    frame_start_d = snapshot;
    if (!dark) begin
      an_d  = anode_for_slot(idx_q);
      seg_d = cur_seg;
      dp_d  = ~dp_mask[idx_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= SLOT_SEC_ONE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= 4'd0;
      end
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (snapshot) begin
        digit_q[SLOT_SEC_ONE] <= sec_one;
        digit_q[SLOT_SEC_TEN] <= sec_ten;
        digit_q[SLOT_MIN_ONE] <= min_one;
        digit_q[SLOT_MIN_TEN] <= min_ten;
      end
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with SCAN_DIV=8, GUARD=2, BLINK_DIV=64.
// A reference process pushes the expected registered outputs for every clock
// edge into a queue; a monitor pops and compares on the falling edge.
module tb_seven_seg_scan;

  localparam int unsigned SD = 8;
  localparam int unsigned GD = 2;
  localparam int unsigned BD = 64;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  localparam out_t RST_OUT = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sec_one = 4'd0;
  logic [3:0] sec_ten = 4'd0;
  logic [3:0] min_one = 4'd0;
  logic [3:0] min_ten = 4'd0;
  logic [3:0] blink_en = 4'd0;
  logic [3:0] dp_mask = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  seven_seg_scan #(
    .SCAN_DIV  (SD),
    .GUARD     (GD),
    .BLINK_DIV (BD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sec_one     (sec_one),
    .sec_ten     (sec_ten),
    .min_one     (min_one),
    .min_ten     (min_ten),
    .blink_en    (blink_en),
    .dp_mask     (dp_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  out_t exp_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic found_d = 1'b0;
  logic final_req = 1'b0;

  // Hand-written segment table for the display digits.
  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference: expected outputs derived from the number of edges since reset
  // release (n). Slot = (n mod 4*SD) / SD, blink half = (n / BD) mod 2.
  initial begin
    int unsigned n;
    int unsigned pos;
    int unsigned slot;
    int unsigned w;
    int unsigned ph;
    logic [3:0]  snap [4];
    logic        rst_prev;
    out_t        e;
    n = 0;
    rst_prev = 1'b1;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst && !rst_prev) begin
        // Asynchronous assertion mid-cycle: this cycle's outputs are already blank.
        if (exp_q.size() > 0) exp_q[exp_q.size()-1] = RST_OUT;
        n = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
      end else if (clk) begin
        if (rst) begin
          exp_q.push_back(RST_OUT);
          n = 0;
          for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        end else begin
          pos  = n % (4 * SD);
          slot = pos / SD;
          w    = pos % SD;
          ph   = (n / BD) % 2;
          e    = RST_OUT;
          e.fs = (pos == 0);
          if (w >= GD && !(ph == 1 && blink_en[slot])) begin
            e.an  = ~(4'b0001 << slot);
            e.seg = exp_seg(snap[slot]);
            e.dp  = ~dp_mask[slot];
          end
          if (pos == 0) begin
            snap[0] = sec_one;
            snap[1] = sec_ten;
            snap[2] = min_one;
            snap[3] = min_ten;
          end
          exp_q.push_back(e);
          n++;
        end
      end
      rst_prev = rst;
    end
  end

  // Monitor: the only process that counts comparisons.
  initial begin
    out_t e;
    out_t act;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act.an  = an;
        act.seg = seg;
        act.dp  = dp;
        act.fs  = frame_start;
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                   cyc, act.an, act.seg, act.dp, act.fs, e.an, e.seg, e.dp, e.fs);
        end
      end
      if (final_req) begin
        n_chk++;
        if (found_d !== 1'b1) begin
          n_fail++;
          $display("FAIL an_d_seen: got %b, want 1 (an never showed D within budget)", found_d);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    // Reset with random inputs.
    sec_one  = 4'($urandom);
    sec_ten  = 4'($urandom);
    min_one  = 4'($urandom);
    min_ten  = 4'($urandom);
    blink_en = 4'($urandom);
    dp_mask  = 4'($urandom);
    repeat (4) @(negedge clk);
    #1;
    min_ten  = 4'd1;
    min_one  = 4'd3;
    sec_ten  = 4'd5;
    sec_one  = 4'd9;
    dp_mask  = 4'b0100;
    blink_en = 4'b0000;
    rst      = 1'b0;

    // Static scan, then a mid-frame change that must wait for the next snapshot.
    repeat (70) @(negedge clk);
    #1 sec_one = 4'd4;
    repeat (70) @(negedge clk);

    // Blink slot 0 across several half-periods.
    #1 blink_en = 4'b0001;
    repeat (200) @(negedge clk);

    // Invalid BCD in slot 2.
    #1;
    blink_en = 4'b0000;
    min_one  = 4'hC;
    repeat (40) @(negedge clk);

    // Reset pulse while slot 1 is driven.
    for (int i = 0; i < 40 && !found_d; i++) begin
      @(negedge clk);
      if (an == 4'hD) found_d = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);

    #1 final_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("FAIL finish: got no summary, want summary before timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
